// File: rtl/virtual_input_ctrl_if.sv
// Command port between the host-side decoder and the virtual input controller.
// The host drives valid/index/op; the controller answers with ready.
interface virtual_input_ctrl_if #(
    parameter int unsigned IDX_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDX_W-1:0] cmd_index;
    logic [1:0]       cmd_op;

    modport master (
        output cmd_valid,
        output cmd_index,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_index,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/virtual_input_ctrl.sv
// Virtual push-button / slide-switch driver controlled by host commands:
// toggle, set, clear and a timed pulse that restores the original level.
module virtual_input_ctrl #(
    parameter int unsigned          N_BUTTONS    = 4,
    parameter int unsigned          N_SWITCHES   = 18,
    parameter int unsigned          IDX_W        = 5,
    parameter logic                 BUTTON_IDLE  = 1'b1,
    parameter logic [N_SWITCHES-1:0] SWITCH_INIT = '0,
    parameter int unsigned          PULSE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    virtual_input_ctrl_if.slave   cmd,
    output logic [N_BUTTONS-1:0]  buttons,
    output logic [N_SWITCHES-1:0] switches,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned NTOT     = N_BUTTONS + N_SWITCHES;
    localparam int unsigned GLOB_IDX = (32'd1 << IDX_W) - 1;
    localparam int unsigned CW       = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

    // Buttons and switches share one vector: index i lives at bit NTOT-1-i.
    localparam logic [NTOT-1:0] RST_VEC = {{N_BUTTONS{BUTTON_IDLE}}, SWITCH_INIT};
    localparam logic [NTOT-1:0] SET_VEC = {{N_BUTTONS{~BUTTON_IDLE}}, {N_SWITCHES{1'b1}}};
    localparam logic [NTOT-1:0] CLR_VEC = {{N_BUTTONS{BUTTON_IDLE}}, {N_SWITCHES{1'b0}}};

    typedef enum logic {StIdle, StPulse} state_t;

    state_t          state_q, state_d;
    logic [NTOT-1:0] vec_q, vec_d;
    logic [NTOT-1:0] mask_q, mask_d;
    logic [NTOT-1:0] orig_q, orig_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    int unsigned     idx;
    logic            in_range;
    logic            is_glob;
    logic [NTOT-1:0] mask;

    always_comb begin
        idx      = 32'(cmd.cmd_index);
        in_range = idx < NTOT;
        is_glob  = idx == GLOB_IDX;
        mask     = in_range ? (NTOT'(1) << (NTOT - 1 - idx)) : '0;
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        orig_d  = orig_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    if (is_glob) begin
                        vec_d = RST_VEC;
                    end else if (in_range) begin
                        unique case (cmd.cmd_op)
                            2'b00: vec_d = vec_q ^ mask;
                            2'b01: vec_d = (vec_q & ~mask) | (SET_VEC & mask);
                            2'b10: vec_d = (vec_q & ~mask) | (CLR_VEC & mask);
                            default: begin
                                vec_d   = vec_q ^ mask;
                                mask_d  = mask;
                                orig_d  = vec_q & mask;
                                cnt_d   = CNT_LOAD;
                                state_d = StPulse;
                            end
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    vec_d   = (vec_q & ~mask_q) | orig_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= RST_VEC;
            mask_q  <= '0;
            orig_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            orig_q  <= orig_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign buttons       = vec_q[NTOT-1:N_SWITCHES];
    assign switches      = vec_q[N_SWITCHES-1:0];
    assign cmd.cmd_ready = state_q == StIdle;
    assign busy          = state_q != StIdle;
    assign err           = err_q;

endmodule

// File: tb/tb_virtual_input_ctrl.sv
// Bench for virtual_input_ctrl: directed steps plus random commands checked
// against an index-level model, and a second instance with a narrower map.
module tb_virtual_input_ctrl;

    localparam int NB   = 4;
    localparam int NS   = 18;
    localparam int IW   = 5;
    localparam int P    = 4;
    localparam int NTOT = NB + NS;
    localparam logic BIDLE = 1'b1;
    localparam logic [NS-1:0] SW_INIT = 18'h0A5C2;

    localparam int NB2 = 2;
    localparam int NS2 = 10;
    localparam int IW2 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    virtual_input_ctrl_if #(.IDX_W(IW)) cif ();
    logic [NB-1:0] buttons;
    logic [NS-1:0] switches;
    logic          busy, err;

    virtual_input_ctrl #(
        .N_BUTTONS(NB), .N_SWITCHES(NS), .IDX_W(IW), .BUTTON_IDLE(BIDLE),
        .SWITCH_INIT(SW_INIT), .PULSE_CYCLES(P)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cif), .buttons(buttons), .switches(switches),
        .busy(busy), .err(err)
    );

    virtual_input_ctrl_if #(.IDX_W(IW2)) cif2 ();
    logic [NB2-1:0] buttons2;
    logic [NS2-1:0] switches2;
    logic           busy2, err2;

    virtual_input_ctrl #(
        .N_BUTTONS(NB2), .N_SWITCHES(NS2), .IDX_W(IW2), .BUTTON_IDLE(1'b0),
        .SWITCH_INIT('0), .PULSE_CYCLES(3)
    ) dut2 (
        .clk(clk), .rst(rst), .cmd(cif2), .buttons(buttons2), .switches(switches2),
        .busy(busy2), .err(err2)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state is kept per logical input index, not per output bit.
    bit          model_in [NTOT];
    int          pulse_left;
    int          pulse_idx;
    bit          pulse_orig;
    bit          err_m;
    logic [NS-1:0] sw_init_v = SW_INIT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NTOT; i++)
            model_in[i] = (i < NB) ? BIDLE : sw_init_v[NS-1-(i-NB)];
        pulse_left = 0;
        err_m      = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input int idx, input bit [1:0] op);
        bit pressed;
        err_m = 1'b0;
        if (pulse_left > 0) begin
            pulse_left--;
            if (pulse_left == 0) model_in[pulse_idx] = pulse_orig;
        end else if (v) begin
            if (idx == (1 << IW) - 1) begin
                model_reset();
            end else if (idx < NTOT) begin
                pressed = (idx < NB) ? !BIDLE : 1'b1;
                case (op)
                    2'd0: model_in[idx] = !model_in[idx];
                    2'd1: model_in[idx] = pressed;
                    2'd2: model_in[idx] = !pressed;
                    default: begin
                        pulse_orig    = model_in[idx];
                        pulse_idx     = idx;
                        model_in[idx] = !model_in[idx];
                        pulse_left    = P;
                    end
                endcase
            end else begin
                err_m = 1'b1;
            end
        end
    endfunction

    function automatic logic [NB-1:0] exp_buttons();
        logic [NB-1:0] b;
        for (int i = 0; i < NB; i++) b[NB-1-i] = model_in[i];
        return b;
    endfunction

    function automatic logic [NS-1:0] exp_switches();
        logic [NS-1:0] s;
        for (int j = 0; j < NS; j++) s[NS-1-j] = model_in[NB+j];
        return s;
    endfunction

    task automatic check_all(input string ctx);
        chk({ctx, ".buttons"}, 32'(buttons), 32'(exp_buttons()));
        chk({ctx, ".switches"}, 32'(switches), 32'(exp_switches()));
        chk({ctx, ".ready"}, 32'(cif.cmd_ready), 32'(pulse_left == 0));
        chk({ctx, ".busy"}, 32'(busy), 32'(pulse_left != 0));
        chk({ctx, ".err"}, 32'(err), 32'(err_m));
    endtask

    task automatic cycle(input bit v, input int idx, input bit [1:0] op, input string ctx);
        cif.cmd_valid = v;
        cif.cmd_index = idx[IW-1:0];
        cif.cmd_op    = op;
        @(posedge clk);
        model_step(v, idx, op);
        #1;
        check_all(ctx);
    endtask

    task automatic cycle2(input bit v, input int idx, input bit [1:0] op);
        cif2.cmd_valid = v;
        cif2.cmd_index = idx[IW2-1:0];
        cif2.cmd_op    = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        bit v;
        bit [1:0] op;

        rst = 1'b1;
        cif.cmd_valid  = 1'b0;
        cif.cmd_index  = '0;
        cif.cmd_op     = 2'd0;
        cif2.cmd_valid = 1'b0;
        cif2.cmd_index = '0;
        cif2.cmd_op    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        chk("reset.buttons_const", 32'(buttons), 32'hF);
        rst = 1'b0;

        // Toggles on consecutive cycles
        cycle(1'b1, 0, 2'd0, "tog0");
        cycle(1'b1, 2, 2'd0, "tog2");
        cycle(1'b1, 4, 2'd0, "tog4");
        chk("tog.buttons_const", 32'(buttons), 32'h5);
        chk("tog.sw17", 32'(switches[17]), 32'd1);

        // Set twice then clear on the last switch
        cycle(1'b1, 21, 2'd1, "set21a");
        chk("set21a.sw0", 32'(switches[0]), 32'd1);
        cycle(1'b1, 21, 2'd1, "set21b");
        chk("set21b.sw0", 32'(switches[0]), 32'd1);
        cycle(1'b1, 21, 2'd2, "clr21");
        chk("clr21.sw0", 32'(switches[0]), 32'd0);

        // Pulse button idx 1 while a set command is held waiting
        cycle(1'b1, 1, 2'd3, "pulse1");
        chk("pulse1.b2", 32'(buttons[2]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 21, 2'd1, "pulse_hold");
            chk("pulse_hold.b2", 32'(buttons[2]), 32'd0);
            chk("pulse_hold.ready", 32'(cif.cmd_ready), 32'd0);
        end
        cycle(1'b1, 21, 2'd1, "pulse_end");
        chk("pulse_end.b2", 32'(buttons[2]), 32'd1);
        chk("pulse_end.ready", 32'(cif.cmd_ready), 32'd1);
        chk("pulse_end.sw0", 32'(switches[0]), 32'd0);
        cycle(1'b1, 21, 2'd1, "held_accept");
        chk("held_accept.sw0", 32'(switches[0]), 32'd1);

        // Out-of-range indices
        cycle(1'b1, 22, 2'd0, "oor22");
        chk("oor22.err", 32'(err), 32'd1);
        cycle(1'b0, 0, 2'd0, "oor_idle");
        chk("oor_idle.err", 32'(err), 32'd0);
        cycle(1'b1, 30, 2'd3, "oor30");
        chk("oor30.err", 32'(err), 32'd1);

        // Global reset after some sets
        cycle(1'b1, 5, 2'd1, "set5");
        cycle(1'b1, 3, 2'd1, "set3");
        cycle(1'b1, 31, 2'd2, "glob");
        chk("glob.buttons_const", 32'(buttons), 32'hF);
        chk("glob.switches_const", 32'(switches), 32'(SW_INIT));

        // Asynchronous reset in the middle of a pulse
        cycle(1'b1, 0, 2'd3, "rpulse");
        cycle(1'b0, 0, 2'd0, "rpulse2");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cycle(1'b0, 0, 2'd0, "post_rst");

        // Random commands against the model
        for (int n = 0; n < 400; n++) begin
            v   = $urandom_range(0, 9) < 7;
            idx = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, NTOT - 1))
                                              : int'($urandom_range(NTOT, 31));
            op  = 2'($urandom_range(0, 3));
            cycle(v, idx, op, "rand");
        end
        cycle(1'b0, 0, 2'd0, "drain");

        // Second instance: 2 buttons (active-high), 10 switches, 4-bit index
        chk("p2.reset.buttons", 32'(buttons2), 32'd0);
        chk("p2.reset.switches", 32'(switches2), 32'd0);
        cycle2(1'b1, 1, 2'd1);
        chk("p2.set1.buttons", 32'(buttons2), 32'h1);
        cycle2(1'b1, 11, 2'd1);
        chk("p2.set11.switches", 32'(switches2), 32'h001);
        cycle2(1'b1, 12, 2'd0);
        chk("p2.idx12.err", 32'(err2), 32'd1);
        chk("p2.idx12.buttons", 32'(buttons2), 32'h1);
        chk("p2.idx12.switches", 32'(switches2), 32'h001);
        cycle2(1'b1, 15, 2'd3);
        chk("p2.glob.buttons", 32'(buttons2), 32'd0);
        chk("p2.glob.switches", 32'(switches2), 32'd0);
        chk("p2.glob.busy", 32'(busy2), 32'd0);
        cycle2(1'b1, 0, 2'd3);
        chk("p2.pulse.buttons", 32'(buttons2), 32'h2);
        chk("p2.pulse.busy", 32'(busy2), 32'd1);
        cycle2(1'b0, 0, 2'd0);
        cycle2(1'b0, 0, 2'd0);
        chk("p2.pulse3.buttons", 32'(buttons2), 32'h2);
        cycle2(1'b0, 0, 2'd0);
        chk("p2.pulse_end.buttons", 32'(buttons2), 32'h0);
        chk("p2.pulse_end.ready", 32'(cif2.cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/virtual_input_ctrl.md
Name: virtual_input_ctrl

Overview:
Parametrised, clocked controller for virtual board inputs (push-buttons and slide switches) driven by a host command port instead of physical I/O. Each accepted command addresses one input by index and applies an operation: toggle, set, clear, or timed pulse. The block sits between the host-side command decoder and the DUT's button/switch input pins. It adds operations and a timed momentary-press mode to the earlier toggle-only generation.

Parameters:
N_BUTTONS, 4, number of virtual push-buttons
N_SWITCHES, 18, number of virtual slide switches
IDX_W, 5, command index width; must satisfy 2^IDX_W > N_BUTTONS+N_SWITCHES
BUTTON_IDLE, 1, released level of every button (1 = active-low buttons)
SWITCH_INIT, 0 (N_SWITCHES bits), switch values after reset or the global-reset command
PULSE_CYCLES, 1000000, pulse duration in clk cycles, >=1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_index  in  IDX_W  target input index
cmd_op  in  2  00 toggle, 01 set (press/on), 10 clear (release/off), 11 pulse
buttons  out  N_BUTTONS  registered button levels
switches  out  N_SWITCHES  registered switch levels
busy  out  1  pulse in progress (equals ~cmd_ready)
err  out  1  one-cycle flag for an out-of-range index

Behaviour:
- Reset (async, rst=1): buttons={N_BUTTONS{BUTTON_IDLE}}, switches=SWITCH_INIT, state=IDLE, pulse counter=0, err=0, cmd_ready=1, busy=0. Reset mid-pulse aborts the pulse; no restore is pending afterwards.
- Handshake: accept on a rising edge with cmd_valid=1 and cmd_ready=1. cmd_ready=1 only in IDLE. A command held while cmd_ready=0 is not consumed.
- Index map:
  - i < N_BUTTONS -> buttons[N_BUTTONS-1-i].
  - N_BUTTONS <= i < N_BUTTONS+N_SWITCHES -> switches[N_SWITCHES-1-(i-N_BUTTONS)].
  - i = 2^IDX_W-1 -> global reset: all outputs go to their reset values; cmd_op is ignored.
  - Any other index -> no output change, err=1 for one cycle.
- Button polarity: "pressed" = ~BUTTON_IDLE. Set drives pressed, clear drives BUTTON_IDLE. Switch set drives 1, clear drives 0. Toggle inverts the target bit.
- Latency: the output change is visible in the cycle after acceptance; err has the same timing. Non-pulse commands leave the block in IDLE, so back-to-back commands are accepted every cycle.
- FSM IDLE/PULSE:
  - Pulse accepted in IDLE: capture the target, invert the target bit (button -> pressed if released, else released), load counter=PULSE_CYCLES-1, go to PULSE.
  - In PULSE: the counter decrements each cycle. When the counter reaches 0, restore the captured original bit value and go to IDLE.
  - The inverted level is held exactly PULSE_CYCLES cycles. cmd_ready returns high in the same cycle the restored value becomes visible.
- A pulse on an out-of-range index behaves like any out-of-range command (err, stay IDLE). A pulse on the global-reset index performs a plain global reset.
- No other bit changes during a pulse.
- Counter width: $clog2(PULSE_CYCLES+1). There is no wrap-around; the counter is only loaded on pulse acceptance.

Test Plan:
- Reset, then check outputs; then toggle idx 0, 2 and 4 on consecutive cycles -> buttons=4'b0101, switches[17]=1, cmd_ready stays 1, each change lands 1 cycle after acceptance.
- Set idx 21, set idx 21 again, then clear idx 21 -> switches[0]: 1, 1, 0; set is idempotent; err never asserted.
- PULSE_CYCLES=4, pulse idx 1 -> buttons[2]=0 for exactly 4 cycles, then 1. cmd_ready=0 for those 4 cycles. A cmd_valid held during that window is accepted on the first ready cycle.
- Indices 22 and 30 with any op -> err=1 for one cycle each, outputs unchanged. Index 31 after several sets -> buttons=4'hF, switches=SWITCH_INIT.
- Assert rst mid-pulse (cycle 2 of 4) -> immediate reset values, cmd_ready=1, no restore glitch after rst deasserts.
- Re-parametrise N_BUTTONS=2, N_SWITCHES=10, IDX_W=4, BUTTON_IDLE=0 -> idx 1 maps to buttons[0] (set gives 1), idx 11 maps to switches[0], idx 12 raises err, idx 15 performs a global reset.
